rvv_backend_retire_byte_merge: RTL and testbench

RVV_BACKEND_RETIRE_BYTE_MERGE -- requirements
Module: rvv_backend_retire_byte_merge

---
 rtl/rvv_backend_retire_byte_merge.sv | 171 +++++++++++++++++
 tb/tb_rvv_backend_retire_byte_merge.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rvv_backend_retire_byte_merge.sv
// Retire-stage byte merge: applies tail/mask policy per byte, buffers merged VRF writes
// in a small circular FIFO and reports instruction completion with its uop count.
`ifndef VLENB
`define VLENB 16
`endif

module rvv_backend_retire_byte_merge #(
  parameter int unsigned VLENB      = `VLENB,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4:0]              in_vd_addr,
  input  logic [8*VLENB-1:0]      in_result,
  input  logic [8*VLENB-1:0]      in_vd_old,
  input  logic [VLENB-1:0][1:0]   in_vd_type,
  input  logic                    in_vta,
  input  logic                    in_vma,
  input  logic                    in_last_uop,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4:0]              out_wr_addr,
  output logic [8*VLENB-1:0]      out_wr_data,
  output logic [VLENB-1:0]        out_wr_strobe,
  output logic                    out_last,
  output logic                    instr_done,
  output logic [3:0]              instr_uop_cnt
);

  localparam int unsigned VLEN  = 8 * VLENB;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(FIFO_DEPTH - 1);

  localparam logic [1:0] NOT_CHANGE    = 2'd0;
  localparam logic [1:0] BODY_ACTIVE   = 2'd1;
  localparam logic [1:0] BODY_INACTIVE = 2'd2;
  localparam logic [1:0] TAIL          = 2'd3;

  typedef enum logic {IDLE, BUSY} cnt_state_e;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  cnt_state_e       state_q, state_d;
  logic [3:0]       uop_cnt_q, uop_cnt_d;
  logic [3:0]       uop_cnt_inc;
  logic             push, pop;

  logic [VLEN-1:0]  merge_data;
  logic [VLENB-1:0] merge_strb;

  logic [VLEN-1:0]  fifo_data_q [FIFO_DEPTH];
  logic [VLENB-1:0] fifo_strb_q [FIFO_DEPTH];
  logic [4:0]       fifo_addr_q [FIFO_DEPTH];
  logic             fifo_last_q [FIFO_DEPTH];
  logic [3:0]       fifo_cnt_q  [FIFO_DEPTH];

  assign in_ready  = (count_q < CNT_W'(FIFO_DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_wr_addr   = fifo_addr_q[rd_ptr_q];
  assign out_wr_data   = fifo_data_q[rd_ptr_q];
  assign out_wr_strobe = fifo_strb_q[rd_ptr_q];
  assign out_last      = fifo_last_q[rd_ptr_q];
  assign instr_uop_cnt = fifo_cnt_q[rd_ptr_q];
  // A pop in the reset cycle is discarded, so it must not report completion.
  assign instr_done    = pop & fifo_last_q[rd_ptr_q] & ~rst;

  // Per-byte policy merge on the incoming uop.
  always_comb begin
    merge_data = in_vd_old;
    merge_strb = '0;
    for (int unsigned i = 0; i < VLENB; i++) begin
      case (in_vd_type[i])
        BODY_ACTIVE: begin
          merge_data[i*8 +: 8] = in_result[i*8 +: 8];
          merge_strb[i]        = 1'b1;
        end
        BODY_INACTIVE: begin
          if (in_vma) begin
            merge_data[i*8 +: 8] = 8'hFF;
            merge_strb[i]        = 1'b1;
          end
        end
        TAIL: begin
          if (in_vta) begin
            merge_data[i*8 +: 8] = 8'hFF;
            merge_strb[i]        = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign uop_cnt_inc = (uop_cnt_q == 4'd15) ? 4'd15 : uop_cnt_q + 4'd1;

  // Uop counter FSM: next state and count.
  always_comb begin
    state_d   = state_q;
    uop_cnt_d = uop_cnt_q;
    if (push) begin
      case (state_q)
        IDLE: begin
          if (in_last_uop) begin
            uop_cnt_d = 4'd0;
          end else begin
            state_d   = BUSY;
            uop_cnt_d = uop_cnt_inc;
          end
        end
        BUSY: begin
          if (in_last_uop) begin
            state_d   = IDLE;
            uop_cnt_d = 4'd0;
          end else begin
            uop_cnt_d = uop_cnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FIFO pointer and occupancy next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= IDLE;
      uop_cnt_q <= 4'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      uop_cnt_q <= uop_cnt_d;
    end
  end

  // Entry storage is not reset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= merge_data;
      fifo_strb_q[wr_ptr_q] <= merge_strb;
      fifo_addr_q[wr_ptr_q] <= in_vd_addr;
      fifo_last_q[wr_ptr_q] <= in_last_uop;
      fifo_cnt_q[wr_ptr_q]  <= uop_cnt_inc;
    end
  end

endmodule

// File: tb/tb_rvv_backend_retire_byte_merge.sv
// Directed bench for rvv_backend_retire_byte_merge with hand-computed expected values.
module tb_rvv_backend_retire_byte_merge;

  localparam int unsigned VLENB = 16;
  localparam int unsigned VLEN  = 128;
  localparam logic [31:0] ALL_BA = 32'h5555_5555;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [4:0]            in_vd_addr;
  logic [VLEN-1:0]       in_result;
  logic [VLEN-1:0]       in_vd_old;
  logic [VLENB-1:0][1:0] in_vd_type;
  logic                  in_vta;
  logic                  in_vma;
  logic                  in_last_uop;
  logic                  out_valid;
  logic                  out_ready;
  logic [4:0]            out_wr_addr;
  logic [VLEN-1:0]       out_wr_data;
  logic [VLENB-1:0]      out_wr_strobe;
  logic                  out_last;
  logic                  instr_done;
  logic [3:0]            instr_uop_cnt;

  int n_vec = 0;
  int n_err = 0;

  rvv_backend_retire_byte_merge #(.VLENB(VLENB), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_vd_addr(in_vd_addr),
    .in_result(in_result), .in_vd_old(in_vd_old), .in_vd_type(in_vd_type),
    .in_vta(in_vta), .in_vma(in_vma), .in_last_uop(in_last_uop),
    .out_valid(out_valid), .out_ready(out_ready), .out_wr_addr(out_wr_addr),
    .out_wr_data(out_wr_data), .out_wr_strobe(out_wr_strobe), .out_last(out_last),
    .instr_done(instr_done), .instr_uop_cnt(instr_uop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic [4:0] addr, input logic [VLEN-1:0] res,
                       input logic [31:0] types, input logic last);
    in_valid    = 1'b1;
    in_vd_addr  = addr;
    in_result   = res;
    in_vd_type  = types;
    in_last_uop = last;
  endtask

  // Policy-merge vectors: bytes 0-3 NOT_CHANGE, 4-7 BODY_ACTIVE, 8-11 BODY_INACTIVE, 12-15 TAIL.
  logic [1:0]      mix_pol  [3] = '{2'b01, 2'b10, 2'b11};  // {vta, vma}
  logic [15:0]     mix_strb [3] = '{16'h0FF0, 16'hF0F0, 16'hFFF0};
  logic [VLEN-1:0] mix_data [3] = '{
    128'h11111111_FFFFFFFF_C3C3C3C3_11111111,
    128'hFFFFFFFF_11111111_C3C3C3C3_11111111,
    128'hFFFFFFFF_FFFFFFFF_C3C3C3C3_11111111};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_vd_addr = '0; in_result = '0; in_vd_old = '0;
    in_vd_type = '0; in_vta = 1'b0; in_vma = 1'b0; in_last_uop = 1'b0; out_ready = 1'b0;
    repeat (2) tick();
    settle();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_instr_done", instr_done, 0);
    rst = 1'b0;

    // Single all-active last uop.
    out_ready = 1'b1;
    drive(5'd3, {16{8'hA5}}, ALL_BA, 1'b1);
    tick();
    in_valid = 1'b0;
    settle();
    check("single_valid", out_valid, 1);
    check("single_data", out_wr_data, {16{8'hA5}});
    check("single_strobe", out_wr_strobe, 16'hFFFF);
    check("single_addr", out_wr_addr, 5'd3);
    check("single_last", out_last, 1);
    check("single_done", instr_done, 1);
    check("single_cnt", instr_uop_cnt, 4'd1);
    tick();
    settle();
    check("single_empty", out_valid, 0);
    check("single_done_clr", instr_done, 0);

    // Mixed byte types under each policy combination.
    in_vd_old = {16{8'h11}};
    for (int k = 0; k < 3; k++) begin
      {in_vta, in_vma} = mix_pol[k];
      drive(5'd7, {16{8'hC3}}, 32'hFFAA_5500, 1'b1);
      tick();
      in_valid = 1'b0;
      settle();
      check("mix_data", out_wr_data, mix_data[k]);
      check("mix_strobe", out_wr_strobe, mix_strb[k]);
      check("mix_done", instr_done, 1);
      tick();
    end
    in_vta = 1'b0; in_vma = 1'b0;

    // Backpressure with a full two-entry FIFO, no bypass while full.
    out_ready = 1'b0;
    drive(5'd1, {16{8'h01}}, ALL_BA, 1'b0);
    tick();
    drive(5'd2, {16{8'h02}}, ALL_BA, 1'b0);
    tick();
    drive(5'd3, {16{8'h03}}, ALL_BA, 1'b1);
    settle();
    check("bp_full_ready", in_ready, 0);
    check("bp_head_addr", out_wr_addr, 5'd1);
    tick();
    settle();
    check("bp_hold_ready", in_ready, 0);
    check("bp_hold_addr", out_wr_addr, 5'd1);
    check("bp_hold_data", out_wr_data, {16{8'h01}});
    out_ready = 1'b1;
    settle();
    check("bp_no_bypass", in_ready, 0);
    check("bp_first_done", instr_done, 0);
    tick();
    settle();
    check("bp_ready_again", in_ready, 1);
    check("bp_second_addr", out_wr_addr, 5'd2);
    tick();
    in_valid = 1'b0;
    settle();
    check("bp_third_valid", out_valid, 1);
    check("bp_third_addr", out_wr_addr, 5'd3);
    check("bp_third_data", out_wr_data, {16{8'h03}});
    check("bp_third_done", instr_done, 1);
    check("bp_third_cnt", instr_uop_cnt, 4'd3);
    tick();
    settle();
    check("bp_drained", out_valid, 0);

    // Four-uop instruction then one-uop instruction, streaming.
    for (int k = 0; k < 5; k++) begin
      drive(5'(k + 8), {16{8'(k)}}, ALL_BA, (k >= 3));
      tick();
      settle();
      check("seq_addr", out_wr_addr, 5'(k + 8));
      check("seq_done", instr_done, (k >= 3));
      if (k >= 3) check("seq_cnt", instr_uop_cnt, (k == 3) ? 4'd4 : 4'd1);
    end
    in_valid = 1'b0;
    tick();
    settle();
    check("seq_idle_done", instr_done, 0);

    // Seventeen-uop instruction saturates the reported count at 15.
    for (int k = 0; k < 17; k++) begin
      drive(5'd20, {16{8'h5A}}, ALL_BA, (k == 16));
      tick();
    end
    in_valid = 1'b0;
    settle();
    check("sat_done", instr_done, 1);
    check("sat_cnt", instr_uop_cnt, 4'd15);
    tick();

    // Reset with two buffered entries discards them.
    out_ready = 1'b0;
    drive(5'd11, {16{8'h77}}, ALL_BA, 1'b0);
    tick();
    drive(5'd12, {16{8'h78}}, ALL_BA, 1'b0);
    tick();
    in_valid = 1'b0;
    settle();
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_ready", in_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    settle();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_done", instr_done, 0);
    drive(5'd9, {16{8'h99}}, ALL_BA, 1'b1);
    tick();
    in_valid = 1'b0;
    settle();
    check("post_rst_addr", out_wr_addr, 5'd9);
    check("post_rst_done", instr_done, 1);
    check("post_rst_cnt", instr_uop_cnt, 4'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
